// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad and emits debounced key events.
// Latency: event pulse arrives DEBOUNCE_N+1 clk cycles after the column sample that saw the key.
// Backpressure: none; pulses are fire-and-forget, one per physical press, never on consecutive cycles.
//
// Ports:
//   clk, resetn          system clock, asynchronous active-low reset
//   row_n[3:0]           keypad rows (active-low, asynchronous to clk)
//   col_n[3:0]           column drive (active-low one-hot)
//   num/OP/C/EQ          one-cycle registered pulses: digit / operator / clear / equals accepted
//   digit[3:0]           last accepted digit (0-9)
//   op_code[1:0]         last accepted operator (00 +, 01 -, 10 *, 11 /)
//   key_down             high from accepted press until accepted release
module keypad_scanner #(
  parameter int SCAN_DIV   = 16,
  parameter int DEBOUNCE_N = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       num,
  output logic       OP,
  output logic       C,
  output logic       EQ,
  output logic [3:0] digit,
  output logic [1:0] op_code,
  output logic       key_down
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE_N + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_N - 1);

  typedef enum logic [2:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESS,
    ST_HOLD,
    ST_RELEASE
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       row_s1_q, row_s2_q;
  logic [1:0]       col_q, col_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic [1:0]       row_q, row_d;
  logic             num_q, num_d;
  logic             op_q, op_d;
  logic             clr_q, clr_d;
  logic             eq_q, eq_d;
  logic [3:0]       digit_q, digit_d;
  logic [1:0]       op_code_q, op_code_d;
  logic             key_down_q, key_down_d;

  logic             one_low;
  logic [1:0]       hit_row;
  logic [3:0]       row_pat;
  logic [3:0]       key_val;

  // Exactly-one-row-low detection on the synchronized rows.
  always_comb begin
    one_low = 1'b1;
    hit_row = 2'd0;
    case (row_s2_q)
      4'b1110: hit_row = 2'd0;
      4'b1101: hit_row = 2'd1;
      4'b1011: hit_row = 2'd2;
      4'b0111: hit_row = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  // Row pattern that must persist while debouncing the latched key.
  assign row_pat = ~(4'b0001 << row_q);
  // Digit value for the 3x3 numeric block: row*3 + col + 1.
  assign key_val = ({2'b00, row_q} * 4'd3) + {2'b00, col_q} + 4'd1;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    div_d      = div_q;
    deb_d      = deb_q;
    row_d      = row_q;
    num_d      = 1'b0;
    op_d       = 1'b0;
    clr_d      = 1'b0;
    eq_d       = 1'b0;
    digit_d    = digit_q;
    op_code_d  = op_code_q;
    key_down_d = key_down_q;

    case (state_q)
      ST_SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (one_low) begin
            // Column stays frozen on the detected key from here until release.
            row_d   = hit_row;
            deb_d   = '0;
            state_d = ST_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      ST_DEBOUNCE: begin
        if (row_s2_q == row_pat) begin
          if (deb_q == DEB_LAST) begin
            state_d    = ST_PRESS;
            deb_d      = '0;
            key_down_d = 1'b1;
            if (col_q == 2'd3) begin
              op_d      = 1'b1;
              op_code_d = row_q;
            end else if (row_q == 2'd3) begin
              case (col_q)
                2'd0: clr_d = 1'b1;
                2'd1: begin
                  num_d   = 1'b1;
                  digit_d = 4'd0;
                end
                default: eq_d = 1'b1;
              endcase
            end else begin
              num_d   = 1'b1;
              digit_d = key_val;
            end
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end else begin
          // Bounce: give up on this column and move on.
          state_d = ST_SCAN;
          col_d   = col_q + 2'd1;
          div_d   = '0;
        end
      end

      ST_PRESS: state_d = ST_HOLD;

      ST_HOLD: begin
        if (row_s2_q == 4'hF) begin
          state_d = ST_RELEASE;
          deb_d   = '0;
        end
      end

      ST_RELEASE: begin
        if (row_s2_q == 4'hF) begin
          if (deb_q == DEB_LAST) begin
            state_d    = ST_SCAN;
            key_down_d = 1'b0;
            col_d      = 2'd0;
            div_d      = '0;
            deb_d      = '0;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end else begin
          state_d = ST_HOLD;
          deb_d   = '0;
        end
      end

      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_SCAN;
      row_s1_q   <= 4'hF;
      row_s2_q   <= 4'hF;
      col_q      <= 2'd0;
      div_q      <= '0;
      deb_q      <= '0;
      row_q      <= 2'd0;
      num_q      <= 1'b0;
      op_q       <= 1'b0;
      clr_q      <= 1'b0;
      eq_q       <= 1'b0;
      digit_q    <= 4'd0;
      op_code_q  <= 2'd0;
      key_down_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_s1_q   <= row_n;
      row_s2_q   <= row_s1_q;
      col_q      <= col_d;
      div_q      <= div_d;
      deb_q      <= deb_d;
      row_q      <= row_d;
      num_q      <= num_d;
      op_q       <= op_d;
      clr_q      <= clr_d;
      eq_q       <= eq_d;
      digit_q    <= digit_d;
      op_code_q  <= op_code_d;
      key_down_q <= key_down_d;
    end
  end

  assign col_n    = ~(4'b0001 << col_q);
  assign num      = num_q;
  assign OP       = op_q;
  assign C        = clr_q;
  assign EQ       = eq_q;
  assign digit    = digit_q;
  assign op_code  = op_code_q;
  assign key_down = key_down_q;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 16: clock cycles each column is driven before the rows are sampled (minimum 4).
REQ-002 Parameter DEBOUNCE_N, default 8: consecutive stable clock cycles required to accept a press or a release (minimum 2).
REQ-003 clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 row_n  input  4  keypad rows, active-low (pull-ups external), asynchronous to clk.
REQ-006 col_n  output  4  keypad column drive, active-low one-hot.
REQ-007 num  output  1  one-cycle pulse: digit key accepted.
REQ-008 OP  output  1  one-cycle pulse: operator key accepted.
REQ-009 C  output  1  one-cycle pulse: clear key accepted.
REQ-010 EQ  output  1  one-cycle pulse: equals key accepted.
REQ-011 digit  output  4  value 0-9 of the last accepted digit key, held until the next digit.
REQ-012 op_code  output  2  last accepted operator (00 +, 01 -, 10 *, 11 /), held until the next operator.
REQ-013 key_down  output  1  high from an accepted press until its release is accepted.

Function
REQ-014 row_n SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-015 Key map (row,col): r0 = 1 2 3 +; r1 = 4 5 6 -; r2 = 7 8 9 *; r3 = C 0 EQ /.
REQ-016 FSM states: SCAN, DEBOUNCE, PRESS, HOLD, RELEASE; encoding is free.
REQ-017 SCAN: col_n SHALL hold one column low for SCAN_DIV cycles, sampling the rows on the last cycle, then advance c0->c1->c2->c3->c0.
REQ-018 SCAN sample with exactly one row low SHALL latch (row,col), freeze col_n and go to DEBOUNCE; zero rows or 2+ rows low SHALL continue scanning.
REQ-019 DEBOUNCE: counter SHALL increment each cycle the synchronized rows equal the latched pattern; any mismatch SHALL return to SCAN at the next column with nothing emitted.
REQ-020 Counter reaching DEBOUNCE_N SHALL enter PRESS; PRESS SHALL last exactly one cycle, then go to HOLD.
REQ-021 In PRESS exactly one of num/OP/C/EQ SHALL be high, per the map; all four are registered outputs.
REQ-022 digit or op_code SHALL update in the same cycle as its num or OP pulse; C and EQ SHALL leave both unchanged.
REQ-023 key_down SHALL rise with the pulse and fall on the cycle RELEASE completes.
REQ-024 HOLD SHALL wait, col_n frozen, until all rows are high; then go to RELEASE. No further pulses SHALL occur while held (no auto-repeat).
REQ-025 RELEASE SHALL require DEBOUNCE_N consecutive all-high cycles; any low row SHALL return to HOLD with the counter cleared.
REQ-026 After RELEASE, scanning SHALL resume at column 0 with a fresh SCAN_DIV dwell.
REQ-027 A second key pressed while one is held SHALL be ignored until both are released.
REQ-028 Latency: the pulse SHALL occur DEBOUNCE_N+1 cycles after the SCAN sample that detected the key.
REQ-029 At most one pulse SHALL be emitted per physical press; pulses on consecutive cycles are impossible.

Reset
REQ-030 resetn low SHALL immediately force: col_n=4'b1110, num=OP=C=EQ=0, digit=0, op_code=00, key_down=0, state SCAN, all counters and synchronizer flops 0/idle (synchronizer to 4'b1111).
REQ-031 Reset asserted during DEBOUNCE, PRESS or HOLD SHALL abort without a pulse; after release, a still-held key SHALL be re-detected as a new press.

Verification
REQ-032 Press "7" (r2,c0) held 100 cycles, then release -> single num pulse, digit=7, key_down high until release debounce ends; no other pulse.
REQ-033 Press "/" (r3,c3) bouncing 3 cycles low / 2 high for 20 cycles, then stable -> exactly one OP pulse, op_code=11, DEBOUNCE_N+1 cycles after the first stable detecting sample.
REQ-034 Sequence 1, +, 2, EQ, C -> pulses num(1), OP(00), num(2), EQ, C in order; digit=2, op_code=00 at end.
REQ-035 Rows r0 and r1 low together in one column -> scanning continues, no pulse, key_down stays 0.
REQ-036 Hold "5", assert resetn low for 3 cycles mid-HOLD, release reset with key still held -> outputs at reset values during reset, then one new num pulse with digit=5.
REQ-037 Release glitch (rows high for DEBOUNCE_N-1 cycles, then low, then high) -> key_down stays high through the glitch, no second pulse, key_down falls only after a full DEBOUNCE_N high run.
